// File: rtl/kf8237_dma_page_and_address_latch.sv
// KF8237 companion: XT page registers, A15:A8 latch and
// DMA service-window tracking for the 20-bit memory address.
module kf8237_dma_page_and_address_latch #(
  parameter bit DACK_ACTIVE_LOW = 1'b1,
  parameter bit PAGE_READABLE   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        chip_select_n,
  input  logic        io_write_n,
  input  logic        io_read_n,
  input  logic [1:0]  address_in,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  data_bus_out,
  input  logic [7:0]  dma_data_bus,
  input  logic        output_highst_address,
  input  logic        address_strobe,
  input  logic        address_enable,
  input  logic [3:0]  dma_acknowledge,
  input  logic [7:0]  dma_address_low,
  output logic [19:0] dma_address,
  output logic        dma_address_valid,
  output logic [1:0]  active_channel,
  output logic        write_collision
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        w_capture;

  logic [3:0]  r_page [4];
  logic [3:0]  r_page_q;
  logic [7:0]  r_hi;
  logic [1:0]  r_act_ch;

  logic        r_wr_pend;
  logic [3:0]  r_wr_data;
  logic [1:0]  r_wr_idx;

  logic        w_wr_low;
  logic        w_commit;
  logic [3:0]  w_dack;
  logic [1:0]  w_dack_ch;
  logic [1:0]  w_dack_idx;
  logic [1:0]  w_act_idx;
  logic        w_hit_active;
  logic        w_hit_capture;
  logic        w_unused_hi;

  // XT wiring: idx0=ch0, idx1=ch2, idx2=ch3, idx3=ch1
  function automatic logic [1:0] ch_to_idx(
    input logic [1:0] ch
  );
    logic [1:0] idx;
    case (ch)
      2'd0:    idx = 2'd0;
      2'd1:    idx = 2'd3;
      2'd2:    idx = 2'd1;
      default: idx = 2'd2;
    endcase
    return idx;
  endfunction

  assign w_unused_hi = ^data_bus_in[7:4];

  assign w_wr_low = ~chip_select_n & ~io_write_n;
  // commit is keyed only on the strobe rising, so
  // dropping chip select in that cycle still commits once
  assign w_commit = r_wr_pend & io_write_n & ~reset;

  assign w_dack = DACK_ACTIVE_LOW ? ~dma_acknowledge
                                  : dma_acknowledge;

  // lowest acknowledged channel wins
  always_comb begin
    w_dack_ch = 2'd0;
    priority case (1'b1)
      w_dack[0]: w_dack_ch = 2'd0;
      w_dack[1]: w_dack_ch = 2'd1;
      w_dack[2]: w_dack_ch = 2'd2;
      w_dack[3]: w_dack_ch = 2'd3;
      default:   w_dack_ch = 2'd0;
    endcase
  end

  assign w_dack_idx = ch_to_idx(w_dack_ch);
  assign w_act_idx  = ch_to_idx(r_act_ch);

  // sample CPU write data while the strobe is low
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_pend <= 1'b0;
      r_wr_data <= 4'h0;
      r_wr_idx  <= 2'd0;
    end else if (w_wr_low) begin
      r_wr_pend <= 1'b1;
      r_wr_data <= data_bus_in[3:0];
      r_wr_idx  <= address_in;
    end else if (w_commit) begin
      r_wr_pend <= 1'b0;
    end
  end

  // page register file, updated on strobe release
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_page[i] <= 4'h0;
      end
    end else if (w_commit) begin
      r_page[r_wr_idx] <= r_wr_data;
    end
  end

  // CPU read-back of the addressed page register
  always_comb begin
    data_bus_out = 8'h00;
    if (PAGE_READABLE && !chip_select_n && !io_read_n) begin
      data_bus_out = {4'h0, r_page[address_in]};
    end
  end

  // A15:A8 latch, loaded whenever the 8237 strobes it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi <= 8'h00;
    end else if (address_strobe && output_highst_address) begin
      r_hi <= dma_data_bus;
    end
  end

  // window FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // window FSM: next state and capture strobe
  always_comb begin
    w_state_nx = r_state;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (address_enable) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_dack != 4'h0) begin
          w_state_nx = S_ACTIVE;
          w_capture  = 1'b1;
        end else if (!address_enable) begin
          w_state_nx = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!address_enable) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // snapshot channel and page on entry to a window;
  // the page read sees the pre-commit value
  always_ff @(posedge clock) begin
    if (reset) begin
      r_act_ch <= 2'd0;
      r_page_q <= 4'h0;
    end else if (w_capture) begin
      r_act_ch <= w_dack_ch;
      r_page_q <= r_page[w_dack_idx];
    end
  end

  assign w_hit_active  = (r_state == S_ACTIVE) &&
                         (r_wr_idx == w_act_idx);
  assign w_hit_capture = w_capture &&
                         (r_wr_idx == w_dack_idx);

  assign write_collision = w_commit &
                           (w_hit_active | w_hit_capture);

  assign dma_address       = {r_page_q, r_hi, dma_address_low};
  assign dma_address_valid = (r_state == S_ACTIVE);
  assign active_channel    = r_act_ch;

endmodule

// File: tb/tb_kf8237_dma_page_and_address_latch.sv
// Directed bench for the KF8237 page/address latch:
// expectations queued per step, drained at each sample point.
module tb_kf8237_dma_page_and_address_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        chip_select_n;
  logic        io_write_n;
  logic        io_read_n;
  logic [1:0]  address_in;
  logic [7:0]  data_bus_in;
  logic [7:0]  data_bus_out;
  logic [7:0]  dma_data_bus;
  logic        output_highst_address;
  logic        address_strobe;
  logic        address_enable;
  logic [3:0]  dma_acknowledge;
  logic [7:0]  dma_address_low;
  logic [19:0] dma_address;
  logic        dma_address_valid;
  logic [1:0]  active_channel;
  logic        write_collision;

  always #5 clk = ~clk;

  kf8237_dma_page_and_address_latch #(
    .DACK_ACTIVE_LOW(1'b1),
    .PAGE_READABLE(1'b1)
  ) dut (
    .clock(clk),
    .reset(reset),
    .chip_select_n(chip_select_n),
    .io_write_n(io_write_n),
    .io_read_n(io_read_n),
    .address_in(address_in),
    .data_bus_in(data_bus_in),
    .data_bus_out(data_bus_out),
    .dma_data_bus(dma_data_bus),
    .output_highst_address(output_highst_address),
    .address_strobe(address_strobe),
    .address_enable(address_enable),
    .dma_acknowledge(dma_acknowledge),
    .dma_address_low(dma_address_low),
    .dma_address(dma_address),
    .dma_address_valid(dma_address_valid),
    .active_channel(active_channel),
    .write_collision(write_collision)
  );

  typedef enum int {K_ADDR, K_VALID, K_CH, K_COL, K_DOUT} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [19:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  task automatic want(input string tag, input kind_t k,
                      input logic [19:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [19:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_ADDR:  obs = dma_address;
        K_VALID: obs = {19'b0, dma_address_valid};
        K_CH:    obs = {18'b0, active_channel};
        K_COL:   obs = {19'b0, write_collision};
        default: obs = {12'b0, data_bus_out};
      endcase
      n_total++;
      assert (obs === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    check();
  endtask

  // leaves the bench in the commit cycle
  task automatic cpu_write_start(input logic [1:0] idx,
                                 input logic [7:0] d);
    chip_select_n = 1'b0;
    io_write_n    = 1'b0;
    address_in    = idx;
    data_bus_in   = d;
    repeat (3) tick();
    io_write_n    = 1'b1;
    chip_select_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [1:0] idx,
                           input logic [7:0] d);
    cpu_write_start(idx, d);
    tick();
  endtask

  task automatic read_chk(input string tag, input logic [1:0] idx,
                          input logic [7:0] v);
    chip_select_n = 1'b0;
    io_read_n     = 1'b0;
    address_in    = idx;
    want(tag, K_DOUT, {12'b0, v});
    settle();
    chip_select_n = 1'b1;
    io_read_n     = 1'b1;
  endtask

  initial begin
    reset                 = 1'b1;
    chip_select_n         = 1'b1;
    io_write_n            = 1'b1;
    io_read_n             = 1'b1;
    address_in            = 2'd0;
    data_bus_in           = 8'h00;
    dma_data_bus          = 8'h00;
    output_highst_address = 1'b0;
    address_strobe        = 1'b0;
    address_enable        = 1'b0;
    dma_acknowledge       = 4'hF;
    dma_address_low       = 8'h00;
    tick();
    tick();
    want("rst_addr", K_ADDR, 20'h0);
    want("rst_valid", K_VALID, 20'h0);
    want("rst_ch", K_CH, 20'h0);
    want("rst_col", K_COL, 20'h0);
    want("rst_dout", K_DOUT, 20'h0);
    settle();
    reset = 1'b0;
    tick();

    // page write and read-back
    cpu_write_start(2'd1, 8'hF5);
    want("t1_col_idle", K_COL, 20'h0);
    settle();
    tick();
    read_chk("t1_rd_idx1", 2'd1, 8'h05);
    read_chk("t1_rd_idx0", 2'd0, 8'h00);
    chip_select_n = 1'b0;
    address_in    = 2'd1;
    want("t1_no_read", K_DOUT, 20'h0);
    settle();
    chip_select_n = 1'b1;

    // basic window on ch2
    cpu_write(2'd1, 8'h03);
    address_enable = 1'b1;
    tick();
    address_strobe        = 1'b1;
    output_highst_address = 1'b1;
    dma_data_bus          = 8'hA7;
    dma_acknowledge       = 4'b1011;
    dma_address_low       = 8'h10;
    tick();
    address_strobe        = 1'b0;
    output_highst_address = 1'b0;
    dma_data_bus          = 8'h00;
    want("t2_addr", K_ADDR, 20'h3A710);
    want("t2_valid", K_VALID, 20'h1);
    want("t2_ch", K_CH, 20'h2);
    settle();
    address_enable  = 1'b0;
    dma_acknowledge = 4'hF;
    tick();
    want("t2_valid_off", K_VALID, 20'h0);
    want("t2_ch_hold", K_CH, 20'h2);
    want("t2_addr_hold", K_ADDR, 20'h3A710);
    settle();

    // DACK1+DACK3 together: lowest wins, page from idx3
    cpu_write(2'd3, 8'h0C);
    address_enable = 1'b1;
    tick();
    dma_acknowledge = 4'b0101;
    tick();
    want("t3_ch", K_CH, 20'h1);
    want("t3_addr", K_ADDR, 20'hCA710);
    want("t3_valid", K_VALID, 20'h1);
    settle();
    dma_acknowledge = 4'b1110;
    tick();
    want("t3_no_recap", K_CH, 20'h1);
    settle();
    address_enable  = 1'b0;
    dma_acknowledge = 4'hF;
    tick();

    // collision while active on ch3
    cpu_write(2'd2, 8'h06);
    address_enable = 1'b1;
    tick();
    dma_acknowledge = 4'b0111;
    tick();
    want("t4_addr", K_ADDR, 20'h6A710);
    settle();
    cpu_write_start(2'd0, 8'h01);
    want("t4_col_other", K_COL, 20'h0);
    settle();
    tick();
    cpu_write_start(2'd2, 8'h09);
    want("t4_col", K_COL, 20'h1);
    settle();
    tick();
    want("t4_col_end", K_COL, 20'h0);
    want("t4_addr_snap", K_ADDR, 20'h6A710);
    settle();
    read_chk("t4_rd_idx2", 2'd2, 8'h09);
    address_enable  = 1'b0;
    dma_acknowledge = 4'hF;
    tick();
    address_enable = 1'b1;
    tick();
    dma_acknowledge = 4'b0111;
    tick();
    want("t4_new_page", K_ADDR, 20'h9A710);
    want("t4_new_ch", K_CH, 20'h3);
    settle();
    address_enable  = 1'b0;
    dma_acknowledge = 4'hF;
    tick();

    // commit coincident with capture: old page snapshot
    address_enable = 1'b1;
    tick();
    cpu_write_start(2'd2, 8'h04);
    dma_acknowledge = 4'b0111;
    want("t4_col_same", K_COL, 20'h1);
    settle();
    tick();
    want("t4_snap_old", K_ADDR, 20'h9A710);
    want("t4_same_valid", K_VALID, 20'h1);
    settle();
    read_chk("t4_rd_new", 2'd2, 8'h04);

    // reset mid-window with a write pending
    chip_select_n = 1'b0;
    io_write_n    = 1'b0;
    address_in    = 2'd2;
    data_bus_in   = 8'h0E;
    tick();
    reset           = 1'b1;
    chip_select_n   = 1'b1;
    address_enable  = 1'b0;
    dma_acknowledge = 4'hF;
    dma_address_low = 8'h00;
    tick();
    want("t5_addr", K_ADDR, 20'h0);
    want("t5_valid", K_VALID, 20'h0);
    want("t5_ch", K_CH, 20'h0);
    want("t5_col", K_COL, 20'h0);
    settle();
    reset      = 1'b0;
    io_write_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      read_chk($sformatf("t5_page%0d", i), i[1:0], 8'h00);
    end

    // no carry into page on low-byte wrap
    cpu_write(2'd0, 8'h02);
    address_enable = 1'b1;
    tick();
    address_strobe        = 1'b1;
    output_highst_address = 1'b1;
    dma_data_bus          = 8'hFF;
    dma_acknowledge       = 4'b1110;
    dma_address_low       = 8'hFF;
    tick();
    address_strobe        = 1'b0;
    output_highst_address = 1'b0;
    want("t6_addr_ff", K_ADDR, 20'h2FFFF);
    settle();
    dma_address_low = 8'h00;
    want("t6_no_carry", K_ADDR, 20'h2FF00);
    settle();
    address_enable  = 1'b0;
    dma_acknowledge = 4'hF;
    tick();

    // hi latch in IDLE needs both strobe qualifiers
    address_strobe = 1'b1;
    dma_data_bus   = 8'h12;
    tick();
    address_strobe = 1'b0;
    want("t6_no_ohsa", K_ADDR, 20'h2FF00);
    settle();
    address_strobe        = 1'b1;
    output_highst_address = 1'b1;
    tick();
    address_strobe        = 1'b0;
    output_highst_address = 1'b0;
    want("t6_idle_hi", K_ADDR, 20'h21200);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
